// File: rtl/time_set_pkg.sv
// Shared definitions for the time-setting front end: FSM states, field
// one-hot codes, BCD limits and the BCD increment helper.
package time_set_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_SETUP_H,
    ST_STROBE_H,
    ST_HOLD_H,
    ST_SETUP_M,
    ST_STROBE_M,
    ST_HOLD_M,
    ST_SETUP_S,
    ST_STROBE_S,
    ST_HOLD_S
  } state_t;

  localparam logic [2:0] FLD_H = 3'b100;
  localparam logic [2:0] FLD_M = 3'b010;
  localparam logic [2:0] FLD_S = 3'b001;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two-digit BCD increment; the limit wraps to 00, and anything at or
  // above the limit (or holding a non-decimal digit) also lands on 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if ((v >= lim) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9)) begin
      r = '0;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, level acceptance after
// DEB_CYCLES consecutive samples differing from the accepted level, and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 400000
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  import time_set_pkg::*;

  localparam int unsigned   CW       = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta_q, sync_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button into the CLOCK domain.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Accept a new level only after an unbroken run of differing samples.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync_q == level_q) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= sync_q;
      press_q <= sync_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      press_q <= 1'b0;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting front end: debounced buttons drive an H/M/S edit FSM whose
// commit sequence writes each field through the counters' BCD load port.
module time_set_ctrl #(
  parameter int unsigned DEB_CYCLES   = 400000,
  parameter int unsigned LOAD_CYCLES  = 4,
  parameter int unsigned EDIT_TIMEOUT = 400000000,
  parameter int unsigned BLINK_HALF   = 5000000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [3:0] H0,
  input  logic [3:0] H1,
  input  logic [3:0] M0,
  input  logic [3:0] M1,
  input  logic [3:0] S0,
  input  logic [3:0] S1,
  output logic [3:0] ld0,
  output logic [3:0] ld1,
  output logic       set_h,
  output logic       set_m,
  output logic       set_s,
  output logic [2:0] field_sel,
  output logic       blink,
  output logic       busy
);
  import time_set_pkg::*;

  localparam int unsigned   TW       = cnt_w(EDIT_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(EDIT_TIMEOUT - 1);
  localparam int unsigned   LW       = cnt_w(LOAD_CYCLES);
  localparam logic [LW-1:0] LD_LAST  = LW'(LOAD_CYCLES - 1);
  localparam int unsigned   BW       = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_HALF - 1);

  logic          mode_p, inc_p, ok_p;
  logic [2:0]    btn_level_unused;
  state_t        state_q;
  logic [7:0]    hbuf_q, mbuf_q, sbuf_q, ld_q;
  logic          set_h_q, set_m_q, set_s_q, blink_q, busy_q;
  logic [2:0]    fsel_q;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] lcnt_q;
  logic [BW-1:0] bcnt_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLOCK(CLOCK), .rst(rst), .raw(btn_mode), .level(btn_level_unused[2]), .press(mode_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .CLOCK(CLOCK), .rst(rst), .raw(btn_inc), .level(btn_level_unused[1]), .press(inc_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .CLOCK(CLOCK), .rst(rst), .raw(btn_ok), .level(btn_level_unused[0]), .press(ok_p)
  );

  // Edit/commit FSM; outputs are registered alongside each state change.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hbuf_q  <= '0;
      mbuf_q  <= '0;
      sbuf_q  <= '0;
      ld_q    <= '0;
      set_h_q <= 1'b0;
      set_m_q <= 1'b0;
      set_s_q <= 1'b0;
      fsel_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (mode_p) begin
            hbuf_q  <= {H1, H0};
            mbuf_q  <= {M1, M0};
            sbuf_q  <= {S1, S0};
            ld_q    <= {H1, H0};
            fsel_q  <= FLD_H;
            busy_q  <= 1'b1;
            state_q <= ST_EDIT_H;
          end
        end
        ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
          if (ok_p) begin
            tmo_q   <= '0;
            ld_q    <= hbuf_q;
            fsel_q  <= '0;
            state_q <= ST_SETUP_H;
          end else if (mode_p) begin
            tmo_q <= '0;
            case (state_q)
              ST_EDIT_H: begin state_q <= ST_EDIT_M; fsel_q <= FLD_M; ld_q <= mbuf_q; end
              ST_EDIT_M: begin state_q <= ST_EDIT_S; fsel_q <= FLD_S; ld_q <= sbuf_q; end
              default:   begin state_q <= ST_EDIT_H; fsel_q <= FLD_H; ld_q <= hbuf_q; end
            endcase
          end else if (inc_p) begin
            tmo_q <= '0;
            case (state_q)
              ST_EDIT_H: begin
                hbuf_q <= bcd_inc(hbuf_q, HOUR_MAX);
                ld_q   <= bcd_inc(hbuf_q, HOUR_MAX);
              end
              ST_EDIT_M: begin
                mbuf_q <= bcd_inc(mbuf_q, MINSEC_MAX);
                ld_q   <= bcd_inc(mbuf_q, MINSEC_MAX);
              end
              default: begin
                sbuf_q <= bcd_inc(sbuf_q, MINSEC_MAX);
                ld_q   <= bcd_inc(sbuf_q, MINSEC_MAX);
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            fsel_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_SETUP_H: begin set_h_q <= 1'b1; lcnt_q <= '0; state_q <= ST_STROBE_H; end
        ST_STROBE_H: begin
          if (lcnt_q == LD_LAST) begin set_h_q <= 1'b0; state_q <= ST_HOLD_H; end
          else lcnt_q <= lcnt_q + 1'b1;
        end
        ST_HOLD_H:  begin ld_q <= mbuf_q; state_q <= ST_SETUP_M; end
        ST_SETUP_M: begin set_m_q <= 1'b1; lcnt_q <= '0; state_q <= ST_STROBE_M; end
        ST_STROBE_M: begin
          if (lcnt_q == LD_LAST) begin set_m_q <= 1'b0; state_q <= ST_HOLD_M; end
          else lcnt_q <= lcnt_q + 1'b1;
        end
        ST_HOLD_M:  begin ld_q <= sbuf_q; state_q <= ST_SETUP_S; end
        ST_SETUP_S: begin set_s_q <= 1'b1; lcnt_q <= '0; state_q <= ST_STROBE_S; end
        ST_STROBE_S: begin
          if (lcnt_q == LD_LAST) begin set_s_q <= 1'b0; state_q <= ST_HOLD_S; end
          else lcnt_q <= lcnt_q + 1'b1;
        end
        ST_HOLD_S:  begin busy_q <= 1'b0; state_q <= ST_IDLE; end
        default:    begin busy_q <= 1'b0; fsel_q <= '0; state_q <= ST_IDLE; end
      endcase
    end
  end

  // Blink runs only while a field is being edited; otherwise held low.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (state_q inside {ST_EDIT_H, ST_EDIT_M, ST_EDIT_S}) begin
      if (bcnt_q == BL_LAST) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end else begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end
  end

  assign ld0       = ld_q[3:0];
  assign ld1       = ld_q[7:4];
  assign set_h     = set_h_q;
  assign set_m     = set_m_q;
  assign set_s     = set_s_q;
  assign field_sel = fsel_q;
  assign blink     = blink_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: table of edit/commit vectors plus hand-written
// glitch, simultaneous-press, timeout and mid-commit reset sequences.
`timescale 1ns/1ps
module tb_time_set_ctrl;
  import time_set_pkg::*;

  localparam int DEB   = 4;
  localparam int LOADC = 3;
  localparam int TMO   = 200;
  localparam int BLK   = 8;
  localparam int B_MODE = 0;
  localparam int B_INC  = 1;
  localparam int B_OK   = 2;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0;
  logic [3:0] H0, H1, M0, M1, S0, S1;
  logic [3:0] ld0, ld1;
  logic       set_h, set_m, set_s, blink, busy;
  logic [2:0] field_sel;

  always #5 CLOCK = ~CLOCK;

  time_set_ctrl #(
    .DEB_CYCLES(DEB), .LOAD_CYCLES(LOADC), .EDIT_TIMEOUT(TMO), .BLINK_HALF(BLK)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok),
    .H0(H0), .H1(H1), .M0(M0), .M1(M1), .S0(S0), .S1(S1),
    .ld0(ld0), .ld1(ld1), .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .field_sel(field_sel), .blink(blink), .busy(busy)
  );

  typedef struct {
    logic [2:0] fld;
    logic [7:0] ld;
    int         width;
  } exp_t;

  typedef struct {
    logic [23:0] tm;
    int          nh;
    int          nm;
    int          ns;
    bit          direct;
    logic [23:0] res;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_time(input logic [23:0] t);
    {H1, H0, M1, M0, S1, S0} = t;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      B_MODE:  btn_mode = v;
      B_INC:   btn_inc  = v;
      default: btn_ok   = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    @(negedge CLOCK);
    drive(which, 1'b1);
    repeat (hold) @(negedge CLOCK);
    drive(which, 1'b0);
    repeat (DEB + 4) @(negedge CLOCK);
  endtask

  task automatic end_pulse(input logic [2:0] cur, input logic [7:0] ldv, input int w, input bit bad);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL strobe_unexpected actual=fld%0b/ld%0h required=no_strobe", cur, ldv);
      return;
    end
    e = sb.pop_front();
    check("strobe_fld", 32'(cur), 32'(e.fld));
    check("strobe_ld", 32'(ldv), 32'(e.ld));
    check("strobe_width", 32'(w), 32'(e.width));
    check("strobe_stable", 32'(bad), 32'd0);
  endtask

  // Expects the ok raw input already asserted; follows the commit to its end.
  task automatic commit_watch(input bit rst_inject);
    int         n, cyc, bcyc, w;
    logic [2:0] cur, s;
    logic [7:0] ldv;
    bit         bad, done;
    n = 0;
    while (!(busy && field_sel == 3'b000) && n < 40) begin
      @(negedge CLOCK);
      n++;
    end
    check("commit_start", 32'(busy && field_sel == 3'b000), 32'd1);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_ok = 1'b0;
    cyc = 0; bcyc = 0; w = 0; bad = 1'b0; done = 1'b0; cur = '0; ldv = '0;
    while (busy && !done && cyc < 100) begin
      s = {set_h, set_m, set_s};
      if (field_sel == 3'b000) bcyc++;
      if (s != 3'b000) begin
        if (w == 0) begin
          cur = s;
          ldv = {ld1, ld0};
        end else if (s != cur || {ld1, ld0} != ldv) begin
          bad = 1'b1;
        end
        w++;
        if (rst_inject && s == FLD_M && w == 2) begin
          #2 rst = 1'b1;
          #1;
          check("rst_set_m", 32'(set_m), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_fsel", 32'(field_sel), 32'd0);
          check("rst_ld", 32'({ld1, ld0}), 32'd0);
          end_pulse(cur, ldv, w, bad);
          done = 1'b1;
        end
      end else if (w != 0) begin
        end_pulse(cur, ldv, w, bad);
        w = 0;
        bad = 1'b0;
      end
      if (!done) begin
        @(negedge CLOCK);
        cyc++;
      end
    end
    if (!rst_inject) begin
      check("commit_cycles", 32'(bcyc), 32'(3 * (LOADC + 2)));
      check("commit_done_busy", 32'(busy), 32'd0);
      check("commit_done_fsel", 32'(field_sel), 32'd0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       v;
    int         n, ecyc;
    bit         saw_edit, b0, b1, strobe_seen;

    vecs[0] = '{24'h123456, 0, 0, 0, 1'b1, 24'h123456};
    vecs[1] = '{24'h235959, 1, 1, 2, 1'b0, 24'h000001};
    vecs[2] = '{24'h090909, 1, 1, 1, 1'b0, 24'h101010};
    vecs[3] = '{24'h275A19, 1, 1, 3, 1'b0, 24'h000022};
    vecs[4] = '{24'h194530, 5, 15, 0, 1'b0, 24'h000030};
    vecs[5] = '{24'h000000, 0, 0, 0, 1'b0, 24'h000000};

    set_time(24'h000000);
    repeat (3) @(negedge CLOCK);
    check("reset_ld", 32'({ld1, ld0}), 32'd0);
    check("reset_set", 32'({set_h, set_m, set_s}), 32'd0);
    check("reset_fsel", 32'(field_sel), 32'd0);
    check("reset_blink", 32'(blink), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLOCK);

    // Table-driven edit and commit
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      set_time(v.tm);
      press(B_MODE, 8);
      check("enter_fsel", 32'(field_sel), 32'(FLD_H));
      check("enter_busy", 32'(busy), 32'd1);
      check("enter_ld", 32'({ld1, ld0}), 32'(v.tm[23:16]));
      repeat (v.nh) press(B_INC, 8);
      check("h_ld", 32'({ld1, ld0}), 32'(v.res[23:16]));
      if (!v.direct) begin
        press(B_MODE, 8);
        check("m_fsel", 32'(field_sel), 32'(FLD_M));
        repeat (v.nm) press(B_INC, 8);
        check("m_ld", 32'({ld1, ld0}), 32'(v.res[15:8]));
        press(B_MODE, 8);
        check("s_fsel", 32'(field_sel), 32'(FLD_S));
        repeat (v.ns) press(B_INC, 8);
        check("s_ld", 32'({ld1, ld0}), 32'(v.res[7:0]));
      end
      sb.push_back('{FLD_H, v.res[23:16], LOADC});
      sb.push_back('{FLD_M, v.res[15:8], LOADC});
      sb.push_back('{FLD_S, v.res[7:0], LOADC});
      @(negedge CLOCK);
      btn_ok = 1'b1;
      commit_watch(1'b0);
      check("idle_ld_hold", 32'({ld1, ld0}), 32'(v.res[7:0]));
    end

    // Short glitch, long hold, then mode+ok together in EDIT_M
    set_time(24'h102030);
    press(B_MODE, 8);
    press(B_MODE, 8);
    check("gl_fsel", 32'(field_sel), 32'(FLD_M));
    @(negedge CLOCK);
    btn_inc = 1'b1;
    repeat (3) @(negedge CLOCK);
    btn_inc = 1'b0;
    repeat (12) @(negedge CLOCK);
    check("glitch_ld", 32'({ld1, ld0}), 32'h20);
    press(B_INC, 10);
    check("hold10_ld", 32'({ld1, ld0}), 32'h21);
    sb.push_back('{FLD_H, 8'h10, LOADC});
    sb.push_back('{FLD_M, 8'h21, LOADC});
    sb.push_back('{FLD_S, 8'h30, LOADC});
    @(negedge CLOCK);
    btn_mode = 1'b1;
    btn_ok = 1'b1;
    n = 0;
    while (field_sel == FLD_M && n < 40) begin
      @(negedge CLOCK);
      n++;
    end
    check("both_fsel", 32'(field_sel), 32'd0);
    check("both_busy", 32'(busy), 32'd1);
    commit_watch(1'b0);

    // Edit timeout with no presses
    set_time(24'h080910);
    @(negedge CLOCK);
    btn_mode = 1'b1;
    n = 0; ecyc = 0; saw_edit = 1'b0; b0 = 1'b0; b1 = 1'b0; strobe_seen = 1'b0;
    while (n < 400) begin
      @(negedge CLOCK);
      n++;
      if (n == 8) btn_mode = 1'b0;
      if ({set_h, set_m, set_s} != 3'b000) strobe_seen = 1'b1;
      if (field_sel != 3'b000) begin
        saw_edit = 1'b1;
        ecyc++;
        if (blink) b1 = 1'b1;
        else b0 = 1'b1;
      end else if (saw_edit) begin
        break;
      end
    end
    check("tmo_edit_cycles", 32'(ecyc), 32'(TMO));
    check("tmo_no_strobe", 32'(strobe_seen), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_fsel", 32'(field_sel), 32'd0);
    check("tmo_blink_toggled", 32'(b0 && b1), 32'd1);
    check("tmo_ld_hold", 32'({ld1, ld0}), 32'h08);
    repeat (2) @(negedge CLOCK);
    check("tmo_blink_off", 32'(blink), 32'd0);

    // Reset in the second STROBE_M cycle, then a clean re-entry
    set_time(24'h112233);
    press(B_MODE, 8);
    sb.push_back('{FLD_H, 8'h11, LOADC});
    sb.push_back('{FLD_M, 8'h22, 2});
    @(negedge CLOCK);
    btn_ok = 1'b1;
    commit_watch(1'b1);
    @(negedge CLOCK);
    rst = 1'b0;
    repeat (LOADC + 4) @(negedge CLOCK);
    check("post_rst_set", 32'({set_h, set_m, set_s}), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    press(B_MODE, 8);
    check("reenter_fsel", 32'(field_sel), 32'(FLD_H));
    check("reenter_busy", 32'(busy), 32'd1);
    check("reenter_ld", 32'({ld1, ld0}), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
